fmul_unit: RTL and testbench

FMUL_UNIT -- requirements
Module: fmul_unit

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fmul.sv | 57 +++++
 rtl/fmul_unit.sv | 145 ++++++++++++++
 tb/tb_fmul_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared fp32 field layout, exponent constants and the result record carried from
// the multiplier to the output port of fmul_unit.
package fpu_pkg;

  localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;
  localparam logic [31:0] FP_QNAN      = 32'h7FC0_0000;
  // Widest destination tag a result record can carry; fmul_unit uses the low TAG_W bits.
  localparam int          FP_TAG_MAX_W = 16;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef struct packed {
    logic [31:0]             y;
    logic                    ovf;
    logic [FP_TAG_MAX_W-1:0] tag;
  } fmul_res_t;

endpackage

// File: rtl/fmul.sv
// Combinational fp32 multiplier: truncating, subnormal inputs/results flushed to zero,
// exponent overflow returns signed infinity with ovf raised.
module fmul
  import fpu_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);

  fp32_t             a;
  fp32_t             b;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              sgn;
  logic [47:0]       prod;
  logic [22:0]       mant;
  logic signed [9:0] esum;
  logic [22:0]       unused_prod_lo;

  assign a      = x1;
  assign b      = x2;
  assign sgn    = a.sign ^ b.sign;
  assign a_nan  = (a.exp == FP_EXP_MAX) && (a.mant != '0);
  assign b_nan  = (b.exp == FP_EXP_MAX) && (b.mant != '0);
  assign a_inf  = (a.exp == FP_EXP_MAX) && (a.mant == '0);
  assign b_inf  = (b.exp == FP_EXP_MAX) && (b.mant == '0);
  assign a_zero = (a.exp == '0);
  assign b_zero = (b.exp == '0);

  // Product of two 1.m significands lies in [1,4); bit 47 set means it needs one shift.
  assign prod = {24'd0, 1'b1, a.mant} * {24'd0, 1'b1, b.mant};
  assign mant = prod[47] ? prod[46:24] : prod[45:23];
  assign esum = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - 10'sd127
              + $signed({9'd0, prod[47]});
  assign unused_prod_lo = prod[22:0];

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y = FP_QNAN;
    end else if (a_inf || b_inf) begin
      y = {sgn, FP_EXP_MAX, 23'd0};
    end else if (a_zero || b_zero) begin
      y = {sgn, 31'd0};
    end else if (esum >= 10'sd255) begin
      y   = {sgn, FP_EXP_MAX, 23'd0};
      ovf = 1'b1;
    end else if (esum <= 10'sd0) begin
      y = {sgn, 31'd0};
    end else begin
      y = {sgn, esum[7:0], mant};
    end
  end

endmodule

// File: rtl/fmul_unit.sv
// Two-stage pipelined fp32 multiply unit with tag passthrough and sticky overflow flag.
// Define FMUL_UNIT_SKID_EN for non-stalling stages feeding a 4-entry result FIFO.
module fmul_unit
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_ovf,
  input  logic             flag_clr
);

  // Handshake: a transfer happens at a rising edge where valid and ready are both high;
  // a producer keeps valid and its payload steady until that edge. rst and flush pull
  // both in_ready and out_valid low, so no transfer can coincide with them.

  logic             s0_v;
  logic [31:0]      s0_x1, s0_x2;
  logic [TAG_W-1:0] s0_tag;
  logic             s1_v;
  fmul_res_t        s1_rec;
  logic [31:0]      mul_y;
  logic             mul_ovf;
  fmul_res_t        mul_rec;
  fmul_res_t        head_rec;
  logic             head_v;
  logic             in_ready_base;
  logic             s0_adv, s1_leave;
  logic             accept, out_fire;
  logic             flag_q;
  logic [FP_TAG_MAX_W-1:0] unused_head_tag;

  fmul u_fmul (
    .x1  (s0_x1),
    .x2  (s0_x2),
    .y   (mul_y),
    .ovf (mul_ovf)
  );

  always_comb begin
    mul_rec                  = '0;
    mul_rec.y                = mul_y;
    mul_rec.ovf              = mul_ovf;
    mul_rec.tag[TAG_W-1:0]   = s0_tag;
  end

  assign in_ready  = !rst && !flush && in_ready_base;
  assign accept    = in_valid && in_ready;
  assign out_valid = !rst && !flush && head_v;
  assign out_fire  = out_valid && out_ready;
  assign out_y     = rst ? '0 : head_rec.y;
  assign out_ovf   = rst ? 1'b0 : head_rec.ovf;
  assign out_tag   = rst ? '0 : head_rec.tag[TAG_W-1:0];
  assign flag_ovf  = flag_q && !rst;
  assign unused_head_tag = head_rec.tag;

`ifdef FMUL_UNIT_SKID_EN
  fmul_res_t  fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       push, pop;

  // S1 is the logical tail of the result queue: it is presented directly when the
  // FIFO is empty, otherwise it is appended behind the older FIFO entries.
  assign s0_adv        = s0_v;
  assign s1_leave      = 1'b1;
  assign head_v        = (count != 3'd0) || s1_v;
  assign head_rec      = (count != 3'd0) ? fifo_mem[rd_ptr] : s1_rec;
  assign pop           = out_fire && (count != 3'd0);
  assign push          = s1_v && !(out_fire && (count == 3'd0));
  // Everything accepted but not yet delivered fits in the FIFO, so it can never overflow.
  assign in_ready_base = ({2'b00, s0_v} + {2'b00, s1_v} + count) < 3'd4;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s1_rec;
  end
`else
  assign s0_adv        = s0_v && (!s1_v || out_ready);
  assign s1_leave      = out_fire;
  assign head_v        = s1_v;
  assign head_rec      = s1_rec;
  assign in_ready_base = !s0_v || s0_adv;
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s0_v <= 1'b0;
      s1_v <= 1'b0;
    end else begin
      s0_v <= accept || (s0_v && !s0_adv);
      s1_v <= s0_adv || (s1_v && !s1_leave);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_x1  <= '0;
      s0_x2  <= '0;
      s0_tag <= '0;
      s1_rec <= '0;
    end else begin
      if (accept) begin
        s0_x1  <= in_x1;
        s0_x2  <= in_x2;
        s0_tag <= in_tag;
      end
      if (s0_adv) s1_rec <= mul_rec;
    end
  end

  // Set wins over clear; a flush cycle leaves the flag untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else if (!flush) begin
      if (out_fire && head_rec.ovf) flag_q <= 1'b1;
      else if (flag_clr)            flag_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fmul_unit.sv
// Scoreboard bench for fmul_unit: expected records queued at acceptance, observed
// handshakes queued by a monitor, compared in order by each scenario task.
module tb_fmul_unit;

  localparam int TAG_W = 5;
  localparam int RW    = 33 + TAG_W;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1, in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;
  logic             flag_ovf;
  logic             flag_clr;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int tests  = 0;
  int failed = 0;

  fmul_unit #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_ovf   (out_ovf),
    .out_tag   (out_tag),
    .flag_ovf  (flag_ovf),
    .flag_clr  (flag_clr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every completed output handshake
  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({out_y, out_ovf, out_tag});
  end

  // ---------------- reference model ----------------
  // Truncating fp32 multiply, subnormals as zero, overflow -> signed inf with ovf.
  function automatic logic [32:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e;
    logic        s;
    logic [47:0] p;
    logic [7:0]  e8;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return {32'h7FC00000, 1'b0};
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0))           return {32'h7FC00000, 1'b0};
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0, 1'b0};
    if (ea == 0 || eb == 0)     return {s, 31'd0, 1'b0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin
      p = p >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 1'b1};
    if (e <= 0)   return {s, 31'd0, 1'b0};
    e8 = e[7:0];
    return {s, e8, p[45:23], 1'b0};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    int sel;
    sel = $urandom_range(0, 15);
    m   = 23'($urandom);
    case (sel)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = '0; end
      2, 3:    e = 8'($urandom_range(200, 254));
      4:       e = 8'($urandom_range(1, 40));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t, output bit ok);
    in_x1 = a; in_x2 = b; in_tag = t; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back({fmul_model(a, b), t});
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (got_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    in_valid = 1'b1; in_x1 = 32'h3F800000; in_x2 = 32'h3F800000; in_tag = 5'd9;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_y !== 32'd0)    begin failed++; $display("FAIL reset_out_y got %h exp 0", out_y); end
    tests++; if (out_ovf !== 1'b0)   begin failed++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf); end
    tests++; if (out_tag !== '0)     begin failed++; $display("FAIL reset_out_tag got %0d exp 0", out_tag); end
    tests++; if (flag_ovf !== 1'b0)  begin failed++; $display("FAIL reset_flag_ovf got %b exp 0", flag_ovf); end
    tests++; if (in_ready !== 1'b0)  begin failed++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    int k;
    logic [RW-1:0] g, e;
    out_ready = 1'b1;
    send(32'h3FC00000, 32'h40000000, 5'd3, ok);
    tests++; if (!ok) begin failed++; $display("FAIL basic_accept got no accept exp accept"); end
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin k = i; break; end
    end
    tests++; if (k != 2) begin failed++; $display("FAIL basic_latency got %0d exp 2", k); end
    tests++; if (out_y !== 32'h40400000) begin failed++; $display("FAIL basic_y got %h exp 40400000", out_y); end
    tests++; if (out_ovf !== 1'b0) begin failed++; $display("FAIL basic_ovf got %b exp 0", out_ovf); end
    tests++; if (out_tag !== 5'd3) begin failed++; $display("FAIL basic_tag got %0d exp 3", out_tag); end
    @(posedge clk); #1;
    wait_results(1, ok);
    tests++;
    if (!ok) begin
      failed++; $display("FAIL basic_result timeout got %0d exp 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin failed++; $display("FAIL basic_model got %h exp %h", g, e); end
    end
  endtask

  task automatic test_ovf_flag();
    bit ok;
    logic [RW-1:0] g, e;
    out_ready = 1'b1;
    send(32'h7F000000, 32'h7F000000, 5'd5, ok);
    wait_results(1, ok);
    tests++;
    if (!ok) begin
      failed++; $display("FAIL ovf_result timeout got %0d exp 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin failed++; $display("FAIL ovf_model got %h exp %h", g, e); end
      tests++; if (g[TAG_W] !== 1'b1) begin failed++; $display("FAIL ovf_bit got %b exp 1", g[TAG_W]); end
      tests++; if (g[RW-2 -: 8] !== 8'hFF) begin failed++; $display("FAIL ovf_exp got %h exp ff", g[RW-2 -: 8]); end
    end
    @(negedge clk);
    tests++; if (flag_ovf !== 1'b1) begin failed++; $display("FAIL flag_set got %b exp 1", flag_ovf); end
    @(posedge clk); #1;
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    @(negedge clk);
    tests++; if (flag_ovf !== 1'b0) begin failed++; $display("FAIL flag_clr got %b exp 0", flag_ovf); end
    @(posedge clk); #1;
    // Stall the next overflow result, then release it in the same cycle as flag_clr
    out_ready = 1'b0;
    send(32'hFF000000, 32'h7F000000, 5'd6, ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin failed++; $display("FAIL ovf_stall_valid got 0 exp 1"); end
    tests++; if (flag_ovf !== 1'b0) begin failed++; $display("FAIL flag_no_handshake got %b exp 0", flag_ovf); end
    @(posedge clk); #1;
    out_ready = 1'b1; flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    @(negedge clk);
    tests++; if (flag_ovf !== 1'b1) begin failed++; $display("FAIL flag_set_priority got %b exp 1", flag_ovf); end
    @(posedge clk); #1;
    wait_results(1, ok);
    tests++;
    if (!ok) begin
      failed++; $display("FAIL ovf2_result timeout got %0d exp 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin failed++; $display("FAIL ovf2_model got %h exp %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit send_ok[8];
    bit saw_drop;
    logic [RW-1:0] g, e;
    saw_drop = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(32'h3F800000 + (i << 19), 32'h40000000 + (i << 20), i[TAG_W-1:0], send_ok[i]);
        end
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(negedge clk);
          if (c >= 3 && c <= 4 && !in_ready) saw_drop = 1'b1;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 8; i++) begin
      tests++; if (!send_ok[i]) begin failed++; $display("FAIL b2b_accept[%0d] got no accept exp accept", i); end
    end
`ifndef FMUL_UNIT_SKID_EN
    tests++; if (!saw_drop) begin failed++; $display("FAIL b2b_in_ready_drop got 1 exp 0 within 1 cycle of stall"); end
`endif
    wait_results(8, ok);
    tests++; if (!ok) begin failed++; $display("FAIL b2b_count got %0d exp 8", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      tests++;
      if (g !== e) begin
        failed++;
        $display("FAIL b2b_result got y=%h ovf=%b tag=%0d exp y=%h ovf=%b tag=%0d",
                 g[RW-1 -: 32], g[TAG_W], g[TAG_W-1:0], e[RW-1 -: 32], e[TAG_W], e[TAG_W-1:0]);
      end
    end
  endtask

  task automatic test_flush();
    bit ok;
    int k;
    logic [RW-1:0] g, e;
    out_ready = 1'b1;
    send(32'h7F000000, 32'h7F000000, 5'd1, ok);
    send(32'h3F800000, 32'h40400000, 5'd2, ok);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    repeat (6) @(posedge clk);
    #1;
    tests++; if (got_q.size() != 0) begin failed++; $display("FAIL flush_drop got %0d results exp 0", got_q.size()); end
    got_q.delete();
    tests++; if (flag_ovf !== 1'b1) begin failed++; $display("FAIL flush_flag_keep got %b exp 1", flag_ovf); end
    send(32'h40000000, 32'h40000000, 5'd4, ok);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin k = i; break; end
    end
    tests++; if (k != 2) begin failed++; $display("FAIL flush_next_latency got %0d exp 2", k); end
    @(posedge clk); #1;
    wait_results(1, ok);
    tests++;
    if (!ok) begin
      failed++; $display("FAIL flush_next timeout got %0d exp 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e || g[RW-1 -: 32] !== 32'h40800000)
        begin failed++; $display("FAIL flush_next_result got %h exp %h", g, e); end
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    bit saw_valid;
    out_ready = 1'b1;
    send(32'h3FC00000, 32'h3FC00000, 5'd7, ok);
    send(32'h40000000, 32'h3FC00000, 5'd8, ok);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_mid_valid got %b exp 0", out_valid); end
      tests++; if (flag_ovf !== 1'b0)  begin failed++; $display("FAIL rst_mid_flag got %b exp 0", flag_ovf); end
      tests++; if (in_ready !== 1'b0)  begin failed++; $display("FAIL rst_mid_in_ready got %b exp 0", in_ready); end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rst_mid_release_ready got %b exp 1", in_ready); end
    saw_valid = out_valid;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    tests++; if (saw_valid) begin failed++; $display("FAIL rst_mid_no_result got out_valid=1 exp 0"); end
    tests++; if (got_q.size() != 0) begin failed++; $display("FAIL rst_mid_queue got %0d exp 0", got_q.size()); end
    got_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit ok;
    bit all_ok;
    bit done;
    logic [RW-1:0] g, e;
    all_ok = 1'b1;
    done   = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(rand_fp(), rand_fp(), 5'($urandom_range(0, 31)), ok);
          if (!ok) all_ok = 1'b0;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    tests++; if (!all_ok) begin failed++; $display("FAIL rand_accept got a timeout exp all accepted"); end
    wait_results(exp_q.size(), ok);
    tests++; if (!ok) begin failed++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      tests++;
      if (g !== e) begin
        failed++;
        $display("FAIL rand_result got y=%h ovf=%b tag=%0d exp y=%h ovf=%b tag=%0d",
                 g[RW-1 -: 32], g[TAG_W], g[TAG_W-1:0], e[RW-1 -: 32], e[TAG_W], e[TAG_W-1:0]);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_x1 = '0; in_x2 = '0; in_tag = '0;
    out_ready = 1'b1; flag_clr = 1'b0;
    test_reset();
    test_basic();
    test_ovf_flag();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
